joystick_serial_scanner: RTL and testbench
==========================================

// Module: joystick_serial_scanner
// PURPOSE
//   Sequences an external 74HC165-style parallel-in/serial-out chain that carries
//   two DB9 joysticks, and presents each as a 5-bit FUDLR word (0=pressed).
//   Sits between the joystick connector pins and the joystick protocol decoder,
//   whose db9 input takes joy1_fudlr (or joy2_fudlr) directly. Drives load and
//   shift-clock pins, deserialises frames, debounces over two consecutive frames.
// PARAMETERS
//   CLKDIV    4   clk cycles per tick (one half-period of joy_clk); must be >=2
//   NBITS     16  bits per frame shifted out of the chain
//   GAP_TICKS 64  idle ticks between end of one frame and next LOAD
// PORTS
//   clk          in   1  system clock; all logic on posedge clk
//   rst          in   1  asynchronous reset, active-high
//   enable       in   1  1=scan continuously, 0=stop after current frame
//   joy_load_n   out  1  parallel-load strobe to chain, active-low
//   joy_clk      out  1  shift clock to chain; chain shifts on rising edge
//   joy_data     in   1  serial data from chain (Q7), active-low buttons
//   joy1_fudlr   out  5  joystick 1 {F,U,D,L,R}, 0=pressed
//   joy2_fudlr   out  5  joystick 2 {F,U,D,L,R}, 0=pressed
//   scan_done    out  1  1-clk pulse at end of every frame (COMMIT)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, divider=0, bitcnt=0, shreg=all 1s,
//     prev frame=all 1s, joy_load_n=1, joy_clk=1, joy1/joy2_fudlr=5'b11111,
//     scan_done=0. Deassertion takes effect on next posedge clk.
//   Tick: divider counts 0..CLKDIV-1 freely, wraps; tick=1 for one clk when
//     divider==CLKDIV-1. Every state change except COMMIT happens on a tick.
//   FSM (all outputs registered):
//     IDLE  : load_n=1, clk=1. On tick with enable=1 -> LOAD.
//     LOAD  : load_n=0 for exactly one tick; on tick -> SLOW, bitcnt=0.
//     SLOW  : joy_clk=0. On tick: shreg <= {shreg[NBITS-2:0], joy_data} -> SHIGH.
//     SHIGH : joy_clk=1 (rising edge advances chain). On tick: if
//             bitcnt==NBITS-1 -> COMMIT, else bitcnt+1 -> SLOW.
//     COMMIT: one clk, no tick needed. scan_done=1. If shreg==prev, outputs load
//             from shreg; else outputs hold. prev<=shreg. -> GAP, gapcnt=0.
//     GAP   : on each tick gapcnt+1; when gapcnt==GAP_TICKS-1 on a tick ->
//             LOAD if enable=1, else IDLE.
//   Frame order: first bit sampled lands in shreg[NBITS-1].
//     joy1_fudlr = shreg[15:11], joy2_fudlr = shreg[7:3]; [10:8],[2:0] ignored.
//   Frame length: 1 (LOAD) + 2*NBITS ticks, then 1 clk COMMIT, then GAP_TICKS.
//     Defaults: 33 ticks = 132 clk to COMMIT; next LOAD starts 256 clk later.
//   Debounce: a change appears on outputs only after two identical consecutive
//     frames; output latency from pin change = 1-2 frames. Outputs change only
//     in COMMIT, never mid-frame.
//   enable dropped mid-frame: current frame completes (incl. COMMIT and GAP),
//     then IDLE. enable raised in GAP: no effect until GAP ends.
//   bitcnt width = clog2(NBITS); gapcnt width = clog2(GAP_TICKS); no overflow,
//     both compared for equality before increment.
//   rst mid-frame: immediate return to reset values; partial frame discarded.
// TESTING
//   1 Reset, enable=1, chain model all 1s -> joy_load_n low 4 clk; 16 rising
//     joy_clk edges; scan_done pulse at clk 132+; outputs stay 5'b11111.
//   2 Chain model frame 16'h7FFF (joy1 fire) for 2 frames -> after 1st COMMIT
//     joy1_fudlr=5'b11111; after 2nd COMMIT joy1_fudlr=5'b01111, joy2=5'b11111.
//   3 Alternate frames 16'hFFFF/16'hFF7F -> joy2_fudlr never leaves 5'b11111.
//   4 Frame 16'hF7F7 stable -> joy1_fudlr=5'b11110 (R), joy2_fudlr=5'b11110.
//   5 Drop enable at bit 5 of a frame -> frame completes, one scan_done, GAP of
//     256 clk, then IDLE with joy_load_n=1, joy_clk=1 held.
//   6 Assert rst at bit 9 -> same clk joy_clk=1, load_n=1, outputs 5'b11111;
//     after release next LOAD starts within CLKDIV clk of enable.

Source files
------------

// File: rtl/joystick_serial_scanner.sv
// Scans a 74HC165-style PISO chain carrying two DB9 joysticks and presents each
// as a debounced 5-bit FUDLR word (0 = pressed), updated only at frame commit.
module joystick_serial_scanner #(
  parameter int CLKDIV    = 4,
  parameter int NBITS     = 16,
  parameter int GAP_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       joy_load_n,
  output logic       joy_clk,
  input  logic       joy_data,
  output logic [4:0] joy1_fudlr,
  output logic [4:0] joy2_fudlr,
  output logic       scan_done
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SLOW   = 3'd2,
    S_SHIGH  = 3'd3,
    S_COMMIT = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [DW-1:0]    divider;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] prev_frame;
  logic             tick;
  logic             last_bit;
  logic             last_gap;
  logic             load_n_d;
  logic             clk_d;
  logic             done_d;

  assign tick     = (divider == DW'(CLKDIV - 1));
  assign last_bit = (bitcnt == BW'(NBITS - 1));
  assign last_gap = (gapcnt == GW'(GAP_TICKS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (tick && enable) state_next = S_LOAD;
      S_LOAD:   if (tick) state_next = S_SLOW;
      S_SLOW:   if (tick) state_next = S_SHIGH;
      S_SHIGH:  if (tick) state_next = last_bit ? S_COMMIT : S_SLOW;
      S_COMMIT: state_next = S_GAP;
      S_GAP:    if (tick && last_gap) state_next = enable ? S_LOAD : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pin levels are decoded from the upcoming state so the registered pins
  // change on the same edge as the state register.
  always_comb begin
    load_n_d = (state_next != S_LOAD);
    clk_d    = (state_next != S_SLOW);
    done_d   = (state_next == S_COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      joy_load_n <= 1'b1;
      joy_clk    <= 1'b1;
      scan_done  <= 1'b0;
    end else begin
      joy_load_n <= load_n_d;
      joy_clk    <= clk_d;
      scan_done  <= done_d;
    end
  end

  // Divider, counters, deserialiser and two-frame debounce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider    <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      shreg      <= '1;
      prev_frame <= '1;
      joy1_fudlr <= 5'b11111;
      joy2_fudlr <= 5'b11111;
    end else begin
      divider <= tick ? '0 : divider + 1'b1;
      if (state == S_LOAD && tick) bitcnt <= '0;
      if (state == S_SLOW && tick) shreg <= {shreg[NBITS-2:0], joy_data};
      if (state == S_SHIGH && tick && !last_bit) bitcnt <= bitcnt + 1'b1;
      if (state == S_COMMIT) begin
        gapcnt <= '0;
        // Only a frame seen twice in a row reaches the outputs.
        if (shreg == prev_frame) begin
          joy1_fudlr <= shreg[NBITS-1 -: 5];
          joy2_fudlr <= shreg[NBITS-9 -: 5];
        end
        prev_frame <= shreg;
      end
      if (state == S_GAP && tick && !last_gap) gapcnt <= gapcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_joystick_serial_scanner.sv
// Bench for joystick_serial_scanner: a 74HC165 chain model feeds frames, a
// frame-level debounce model predicts the joystick words every cycle.
module tb_joystick_serial_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       joy_load_n;
  logic       joy_clk;
  logic       joy_data;
  logic [4:0] joy1_fudlr;
  logic [4:0] joy2_fudlr;
  logic       scan_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // chain model state
  logic [15:0] frame_src = 16'hFFFF;
  logic [15:0] chain = 16'hFFFF;
  logic [15:0] loaded_frame = 16'hFFFF;
  int          rises = 0;

  // debounce model state
  logic [15:0] m_prev;
  logic [4:0]  m_j1;
  logic [4:0]  m_j2;
  logic        prev_done;

  joystick_serial_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .joy_load_n (joy_load_n),
    .joy_clk    (joy_clk),
    .joy_data   (joy_data),
    .joy1_fudlr (joy1_fudlr),
    .joy2_fudlr (joy2_fudlr),
    .scan_done  (scan_done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // 74HC165 chain: parallel load on load_n low, shift on rising joy_clk
  assign joy_data = chain[15];
  always @(negedge joy_load_n or posedge joy_clk) begin
    if (!joy_load_n) begin
      chain        = frame_src;
      loaded_frame = frame_src;
      rises        = 0;
    end else begin
      chain = {chain[14:0], 1'b1};
      rises++;
    end
  end

  // scoreboard: outputs follow a frame only once it has been seen twice
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (rst) begin
      m_prev    = 16'hFFFF;
      m_j1      = 5'b11111;
      m_j2      = 5'b11111;
      prev_done = 1'b0;
    end else begin
      chk("joy1_model", joy1_fudlr, m_j1);
      chk("joy2_model", joy2_fudlr, m_j2);
      if (scan_done) begin
        chk("rises_per_frame", rises, 16);
        chk("done_width", prev_done, 0);
        if (loaded_frame == m_prev) begin
          m_j1 = loaded_frame[15:11];
          m_j2 = loaded_frame[7:3];
        end
        m_prev = loaded_frame;
      end
      prev_done = scan_done;
    end
  end

  // wait for scan_done, then one more cycle so committed outputs are visible
  task automatic wait_done(output int t_done);
    int n;
    n = 0;
    t_done = -1;
    while (n < 800) begin
      @(negedge clk);
      n++;
      if (scan_done) begin
        t_done = cyc;
        break;
      end
    end
    if (t_done < 0) chk("scan_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_load(output int t_load);
    int n;
    n = 0;
    t_load = -1;
    while (n < 800) begin
      @(negedge clk);
      n++;
      if (!joy_load_n) begin
        t_load = cyc;
        break;
      end
    end
    if (t_load < 0) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_rises(input int k);
    int n;
    n = 0;
    while (rises < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rises", (rises >= k) ? 1 : 0, 1);
  endtask

  initial begin
    int t_load, t_done, t_load2, n, lows, dones;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    // reset values
    chk("rst_load_n", joy_load_n, 1);
    chk("rst_joy_clk", joy_clk, 1);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_joy1", joy1_fudlr, 5'b11111);
    chk("rst_joy2", joy2_fudlr, 5'b11111);

    // 1: all-ones frame, timing of load strobe, commit and gap
    frame_src = 16'hFFFF;
    rst    = 1'b0;
    enable = 1'b1;
    wait_load(t_load);
    lows = 0;
    n = 0;
    while (!joy_load_n && n < 20) begin
      lows++;
      n++;
      @(negedge clk);
    end
    chk("load_low_clks", lows, 4);
    wait_done(t_done);
    chk("load_to_done", t_done - t_load, 132);
    chk("t1_joy1", joy1_fudlr, 5'b11111);
    chk("t1_joy2", joy2_fudlr, 5'b11111);
    frame_src = 16'h7FFF;
    wait_load(t_load2);
    chk("done_to_next_load", t_load2 - t_done, 256);

    // 2: fire on joy1 needs two frames
    wait_done(t_done);
    chk("t2_first_joy1", joy1_fudlr, 5'b11111);
    frame_src = 16'h7FFF;
    wait_done(t_done);
    chk("t2_second_joy1", joy1_fudlr, 5'b01111);
    chk("t2_second_joy2", joy2_fudlr, 5'b11111);

    // 3: alternating frames never pass the debounce
    for (int i = 0; i < 4; i++) begin
      frame_src = (i % 2 == 0) ? 16'hFFFF : 16'hFF7F;
      wait_done(t_done);
      chk("t3_joy2", joy2_fudlr, 5'b11111);
      chk("t3_joy1", joy1_fudlr, 5'b01111);
    end

    // 4: right on both sticks
    frame_src = 16'hF7F7;
    wait_done(t_done);
    chk("t4_first_joy1", joy1_fudlr, 5'b01111);
    wait_done(t_done);
    chk("t4_joy1", joy1_fudlr, 5'b11110);
    chk("t4_joy2", joy2_fudlr, 5'b11110);

    // 5: enable dropped mid-frame
    wait_load(t_load);
    wait_rises(5);
    enable = 1'b0;
    wait_done(t_done);
    lows  = 0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!joy_load_n) lows++;
      if (scan_done) dones++;
    end
    chk("t5_no_load", lows, 0);
    chk("t5_no_done", dones, 0);
    chk("t5_load_n", joy_load_n, 1);
    chk("t5_joy_clk", joy_clk, 1);
    chk("t5_joy1", joy1_fudlr, 5'b11110);

    // 6: reset in the middle of a frame
    frame_src = 16'h7F7F;
    enable = 1'b1;
    wait_load(t_load);
    wait_rises(9);
    rst = 1'b1;
    #1;
    chk("t6_joy_clk", joy_clk, 1);
    chk("t6_load_n", joy_load_n, 1);
    chk("t6_joy1", joy1_fudlr, 5'b11111);
    chk("t6_joy2", joy2_fudlr, 5'b11111);
    chk("t6_done", scan_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (!joy_load_n) break;
    end
    chk("t6_load_latency", n, 4);
    wait_done(t_done);
    chk("t6_first_joy1", joy1_fudlr, 5'b11111);
    wait_done(t_done);
    chk("t6_joy1", joy1_fudlr, 5'b01111);
    chk("t6_joy2", joy2_fudlr, 5'b01111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
